// File: rtl/bep_frame_pkg.sv
// Shared definitions for the thermostat bus frame (transmit and receive side).
// Contents: frame width, per-field bit offsets, the fixed preamble value, the
// frame-assembly helper and the transmit FSM state type.
package bep_frame_pkg;

   localparam int unsigned FRAME_BITS = 192;

   localparam int unsigned PREAMBLE_MSB      = 191;
   localparam int unsigned PREAMBLE_LSB      = 160;
   localparam int unsigned TYPE_1_MSB        = 159;
   localparam int unsigned TYPE_1_LSB        = 144;
   localparam int unsigned TYPE_2_MSB        = 143;
   localparam int unsigned TYPE_2_LSB        = 128;
   localparam int unsigned CONSTANT_MSB      = 127;
   localparam int unsigned CONSTANT_LSB      = 96;
   localparam int unsigned THERMOSTAT_ID_MSB = 95;
   localparam int unsigned THERMOSTAT_ID_LSB = 64;
   localparam int unsigned ROOM_TEMP_MSB     = 63;
   localparam int unsigned ROOM_TEMP_LSB     = 48;
   localparam int unsigned SET_TEMP_MSB      = 47;
   localparam int unsigned SET_TEMP_LSB      = 32;
   localparam int unsigned STATE_MSB         = 31;
   localparam int unsigned STATE_LSB         = 24;
   localparam int unsigned TAIL_1_MSB        = 23;
   localparam int unsigned TAIL_1_LSB        = 16;
   localparam int unsigned TAIL_2_MSB        = 15;
   localparam int unsigned TAIL_2_LSB        = 8;
   localparam int unsigned TAIL_3_MSB        = 7;
   localparam int unsigned TAIL_3_LSB        = 0;

   localparam logic [31:0] BEP_PREAMBLE = 32'hAAAAAAAA;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } tx_state_e;

   // Concatenates the decoded fields into wire order, preamble in the MSBs.
   function automatic logic [FRAME_BITS-1:0] bep_build_frame(
      input logic [31:0] preamble,
      input logic [15:0] type_1,
      input logic [15:0] type_2,
      input logic [31:0] constant,
      input logic [31:0] thermostat_id,
      input logic [15:0] room_temp,
      input logic [15:0] set_temp,
      input logic [7:0]  state,
      input logic [7:0]  tail_1,
      input logic [7:0]  tail_2,
      input logic [7:0]  tail_3
   );
      return {preamble, type_1, type_2, constant, thermostat_id, room_temp, set_temp,
              state, tail_1, tail_2, tail_3};
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Serial bit-period divider.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   clear         - holds the divider at 0 (the first cycle after release is count 0)
//   mid           - registered, high for the single cycle where the count is CLKS_PER_BIT/2
//   last          - registered, high for the single cycle where the count is CLKS_PER_BIT-1
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic mid,
   output logic last
);

   localparam logic [15:0] MID_COUNT  = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] count_q, count_d;
   logic        mid_q, last_q;

   always_comb begin
      count_d = count_q + 16'd1;
      if (clear || (count_q == LAST_COUNT)) begin
         count_d = '0;
      end
   end

   // Flags are computed from the next count so they line up with count_q.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         mid_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         mid_q   <= (count_d == MID_COUNT);
         last_q  <= (count_d == LAST_COUNT);
      end
   end

   assign mid  = mid_q;
   assign last = last_q;

endmodule

// File: rtl/serial_encode.sv
// Thermostat bus frame serializer: captures the eleven frame fields on an
// accepted start and shifts the 192-bit frame out MSB-first, then idles for
// GAP_CYCLES before pulsing done.
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   start              - send request, accepted only while busy is low
//   preamble..tail_3   - frame fields, sampled on the accepting edge only
//   busy               - frame in flight, from acceptance until done
//   done               - one-cycle pulse at the end of the gap
//   serial_data        - current frame bit (0 outside SEND)
//   serial_clock       - one-cycle strobe mid-way through each bit period
//   bit_index          - bits already strobed in the current frame (0..192)
module serial_encode
   import bep_frame_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned GAP_CYCLES   = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] preamble,
   input  logic [15:0] type_1,
   input  logic [15:0] type_2,
   input  logic [31:0] constant,
   input  logic [31:0] thermostat_id,
   input  logic [15:0] room_temp,
   input  logic [15:0] set_temp,
   input  logic [7:0]  state,
   input  logic [7:0]  tail_1,
   input  logic [7:0]  tail_2,
   input  logic [7:0]  tail_3,
   output logic        busy,
   output logic        done,
   output logic        serial_data,
   output logic        serial_clock,
   output logic [7:0]  bit_index
);

   localparam logic [7:0]  LAST_BIT = 8'(FRAME_BITS - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   tx_state_e             state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [7:0]            bit_q, bit_d;
   logic [15:0]           gap_q, gap_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  timer_clear;
   logic                  bit_mid;
   logic                  bit_last;

   // Divider is held at 0 outside SEND so the first bit period starts clean.
   assign timer_clear = (state_q != StSend);

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clock(clock),
      .reset(reset),
      .clear(timer_clear),
      .mid  (bit_mid),
      .last (bit_last)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               shift_d = bep_build_frame(preamble, type_1, type_2, constant, thermostat_id,
                                         room_temp, set_temp, state, tail_1, tail_2, tail_3);
               bit_d   = '0;
               busy_d  = 1'b1;
               state_d = StSend;
            end
         end
         StSend: begin
            if (bit_last) begin
               // Zeros shift in, so serial_data is 0 once the frame is out.
               shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
               bit_d   = bit_q + 8'd1;
               if (bit_q == LAST_BIT) begin
                  gap_d = '0;
                  if (GAP_CYCLES == 0) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StGap;
                  end
               end
            end
         end
         StGap: begin
            if (gap_q == GAP_LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         shift_q <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign serial_data  = shift_q[FRAME_BITS-1];
   assign serial_clock = bit_mid;
   assign bit_index    = bit_q;

endmodule

// File: tb/tb_serial_encode.sv
// Scoreboard bench for serial_encode: two instances (4/16 and 2/0 timing).
// Expected bits and frames are queued when a send is driven and checked as the
// serializer strobes them out; a loopback receiver rebuilds every field.
module tb_serial_encode;

   localparam int unsigned CA = 4;
   localparam int unsigned GA = 16;
   localparam int unsigned CB = 2;
   localparam int unsigned GB = 0;
   localparam int unsigned NB = 192;
   localparam int FLSB[11] = '{160, 144, 128, 96, 64, 48, 32, 24, 16, 8, 0};
   localparam int FWID[11] = '{32, 16, 16, 32, 32, 16, 16, 8, 8, 8, 8};

   logic        clock;
   logic        reset;
   logic        start_a, start_b;
   logic [31:0] f_pre, f_const, f_id;
   logic [15:0] f_t1, f_t2, f_room, f_set;
   logic [7:0]  f_state, f_tail1, f_tail2, f_tail3;
   logic        busy_a, done_a, sdata_a, sclk_a;
   logic        busy_b, done_b, sdata_b, sclk_b;
   logic [7:0]  bidx_a, bidx_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bit              qa[$];
   bit              qb[$];
   logic [NB-1:0]   fa[$];

   int  fs_a, sc_a, dcnt_a, last_done_a, ones_a, one_idx_a;
   int  fs_b, sc_b, dcnt_b;
   bit  held_mode = 0;
   bit  b2b_armed;
   logic [NB-1:0] rx_a;

   serial_encode #(
      .CLKS_PER_BIT(CA),
      .GAP_CYCLES  (GA)
   ) u_dut_a (
      .clock        (clock),
      .reset        (reset),
      .start        (start_a),
      .preamble     (f_pre),
      .type_1       (f_t1),
      .type_2       (f_t2),
      .constant     (f_const),
      .thermostat_id(f_id),
      .room_temp    (f_room),
      .set_temp     (f_set),
      .state        (f_state),
      .tail_1       (f_tail1),
      .tail_2       (f_tail2),
      .tail_3       (f_tail3),
      .busy         (busy_a),
      .done         (done_a),
      .serial_data  (sdata_a),
      .serial_clock (sclk_a),
      .bit_index    (bidx_a)
   );

   serial_encode #(
      .CLKS_PER_BIT(CB),
      .GAP_CYCLES  (GB)
   ) u_dut_b (
      .clock        (clock),
      .reset        (reset),
      .start        (start_b),
      .preamble     (f_pre),
      .type_1       (f_t1),
      .type_2       (f_t2),
      .constant     (f_const),
      .thermostat_id(f_id),
      .room_temp    (f_room),
      .set_temp     (f_set),
      .state        (f_state),
      .tail_1       (f_tail1),
      .tail_2       (f_tail2),
      .tail_3       (f_tail3),
      .busy         (busy_b),
      .done         (done_b),
      .serial_data  (sdata_b),
      .serial_clock (sclk_b),
      .bit_index    (bidx_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference frame: fields in wire order, preamble first.
   function automatic logic [NB-1:0] frame_of();
      return {f_pre, f_t1, f_t2, f_const, f_id, f_room, f_set, f_state, f_tail1, f_tail2,
              f_tail3};
   endfunction

   function automatic logic [31:0] field_of(input logic [NB-1:0] fr, input int f);
      logic [NB-1:0] m;
      m = (192'(1) << FWID[f]) - 192'(1);
      return 32'((fr >> FLSB[f]) & m);
   endfunction

   task automatic push_a(input logic [NB-1:0] fr);
      for (int i = NB - 1; i >= 0; i--) qa.push_back(fr[i]);
      fa.push_back(fr);
   endtask

   task automatic set_plan_fields();
      f_pre = 32'hAAAAAAAA; f_t1 = 16'hD391; f_t2 = 16'hD391; f_const = 32'h0DFFFFFE;
      f_id = 32'h02391F9F; f_room = 16'h00C0; f_set = 16'h0032; f_state = 8'h19;
      f_tail1 = 8'h14; f_tail2 = 8'h03; f_tail3 = 8'h12;
   endtask

   task automatic set_random_fields();
      f_pre = $urandom; f_t1 = 16'($urandom); f_t2 = 16'($urandom); f_const = $urandom;
      f_id = $urandom; f_room = 16'($urandom); f_set = 16'($urandom);
      f_state = 8'($urandom); f_tail1 = 8'($urandom); f_tail2 = 8'($urandom);
      f_tail3 = 8'($urandom);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(posedge clock);
   endtask

   task automatic send_a(input bit push);
      int req;
      @(posedge clock); #1;
      if (push) push_a(frame_of());
      start_a = 1'b1;
      req = cyc;
      @(posedge clock); #1;
      start_a = 1'b0;
      check_eq("accept_busy_a", busy_a, 1);
      @(negedge clock); #1;
      check_eq("accept_cycle_a", fs_a, req + 1);
   endtask

   task automatic wait_done_a(input int n0, input int limit);
      int t;
      t = 0;
      while (dcnt_a <= n0 && t < limit) begin
         @(posedge clock);
         t++;
      end
      check_eq("done_seen_a", dcnt_a > n0, 1);
      @(posedge clock); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_busy"}, busy_a, 0);
      check_eq({tag, "_done"}, done_a, 0);
      check_eq({tag, "_sdata"}, sdata_a, 0);
      check_eq({tag, "_sclk"}, sclk_a, 0);
      check_eq({tag, "_bidx"}, bidx_a, 0);
   endtask

   // Monitor / loopback receiver for instance A.
   initial begin : mon_a
      logic          prev_busy;
      logic [NB-1:0] ef;
      bit            eb;
      prev_busy = 1'b0; fs_a = 0; sc_a = 0; dcnt_a = 0; last_done_a = 0;
      ones_a = 0; one_idx_a = 0; rx_a = '0; b2b_armed = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_busy = 1'b0;
            b2b_armed = 0;
         end else begin
            if (busy_a && !prev_busy) begin
               fs_a = cyc; sc_a = 0; ones_a = 0; rx_a = '0;
               if (held_mode) begin
                  if (b2b_armed) check_eq("b2b_accept", fs_a, last_done_a + 1);
                  push_a(frame_of());
               end
            end
            if (!busy_a) check_eq("sclk_idle_a", sclk_a, 0);
            if (sclk_a) begin
               check_eq("strobe_time_a", cyc, fs_a + sc_a * CA + CA / 2);
               check_eq("bit_index_a", bidx_a, sc_a);
               check_eq("sb_has_bit_a", qa.size() > 0, 1);
               if (qa.size() > 0) begin
                  eb = qa.pop_front();
                  check_eq("bit_a", sdata_a, eb);
               end
               if (sdata_a) begin
                  ones_a++;
                  one_idx_a = sc_a;
               end
               rx_a = {rx_a[NB-2:0], sdata_a};
               sc_a++;
            end
            if (done_a) begin
               check_eq("done_time_a", cyc, fs_a + NB * CA + GA);
               check_eq("strobes_a", sc_a, NB);
               check_eq("busy_at_done_a", busy_a, 0);
               check_eq("bidx_done_a", bidx_a, NB);
               check_eq("sb_has_frame_a", fa.size() > 0, 1);
               if (fa.size() > 0) begin
                  ef = fa.pop_front();
                  for (int f = 0; f < 11; f++) begin
                     check_eq($sformatf("field%0d_a", f), field_of(rx_a, f), field_of(ef, f));
                  end
               end
               dcnt_a++;
               last_done_a = cyc;
               if (held_mode) b2b_armed = 1;
            end
            prev_busy = busy_a;
         end
      end
   end

   // Monitor for instance B.
   initial begin : mon_b
      logic prev_busy;
      bit   eb;
      prev_busy = 1'b0; fs_b = 0; sc_b = 0; dcnt_b = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_busy = 1'b0;
         end else begin
            if (busy_b && !prev_busy) begin
               fs_b = cyc;
               sc_b = 0;
            end
            if (!busy_b) check_eq("sclk_idle_b", sclk_b, 0);
            if (sclk_b) begin
               check_eq("strobe_time_b", cyc, fs_b + sc_b * CB + CB / 2);
               check_eq("sb_has_bit_b", qb.size() > 0, 1);
               if (qb.size() > 0) begin
                  eb = qb.pop_front();
                  check_eq("bit_b", sdata_b, eb);
               end
               sc_b++;
            end
            if (done_b) begin
               check_eq("done_time_b", cyc, fs_b + NB * CB + GB);
               check_eq("strobes_b", sc_b, NB);
               dcnt_b++;
            end
            prev_busy = busy_b;
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int d0, t, target;
      logic [NB-1:0] fb;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      set_plan_fields();
      repeat (3) @(posedge clock);
      #1;
      check_outputs_zero("reset");
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_outputs_zero("post_reset");

      // Reference frame with loopback of every field.
      d0 = dcnt_a;
      send_a(1);
      wait_done_a(d0, 1000);
      check_eq("bidx_idle_a", bidx_a, NB);

      // Walking one in the very last bit.
      f_pre = '0; f_t1 = '0; f_t2 = '0; f_const = '0; f_id = '0; f_room = '0; f_set = '0;
      f_state = '0; f_tail1 = '0; f_tail2 = '0; f_tail3 = 8'h01;
      d0 = dcnt_a;
      send_a(1);
      wait_done_a(d0, 1000);
      check_eq("walk_ones", ones_a, 1);
      check_eq("walk_index", one_idx_a, NB - 1);

      // Start while busy is ignored, fields changed after acceptance.
      set_plan_fields();
      d0 = dcnt_a;
      send_a(1);
      wait_cyc(fs_a + 99);
      #1;
      set_random_fields();
      start_a = 1'b1;
      @(posedge clock); #1;
      start_a = 1'b0;
      wait_done_a(d0, 1000);
      repeat (20) @(posedge clock);
      #1;
      check_eq("single_done", dcnt_a - d0, 1);
      check_eq("no_restart", busy_a, 0);

      // Reset mid-frame aborts without done; next frame is complete.
      set_random_fields();
      d0 = dcnt_a;
      send_a(1);
      target = fs_a + 299;
      wait_cyc(target);
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("abort");
      qa.delete();
      fa.delete();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check_eq("no_done_on_abort", dcnt_a, d0);
      send_a(1);
      wait_done_a(d0, 1000);

      // Start held high: back-to-back frames.
      set_plan_fields();
      d0 = dcnt_a;
      held_mode = 1;
      @(posedge clock); #1;
      start_a = 1'b1;
      repeat (2000) @(posedge clock);
      #1;
      start_a = 1'b0;
      @(negedge clock);
      t = 0;
      while (busy_a && t < 1000) begin
         @(posedge clock);
         t++;
      end
      @(negedge clock); #1;
      held_mode = 0;
      check_eq("b2b_drained", busy_a, 0);
      check_eq("b2b_frames", (dcnt_a - d0) >= 3, 1);

      // Fast instance: CLKS_PER_BIT=2, no gap.
      set_random_fields();
      fb = frame_of();
      d0 = dcnt_b;
      @(posedge clock); #1;
      for (int i = NB - 1; i >= 0; i--) qb.push_back(fb[i]);
      start_b = 1'b1;
      @(posedge clock); #1;
      start_b = 1'b0;
      t = 0;
      while (dcnt_b <= d0 && t < 600) begin
         @(posedge clock);
         t++;
      end
      check_eq("done_seen_b", dcnt_b - d0, 1);

      repeat (4) @(posedge clock);
      #1;
      check_eq("qa_empty", qa.size(), 0);
      check_eq("fa_empty", fa.size(), 0);
      check_eq("qb_empty", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_encode.md
# serial_encode

Serializer for the thermostat bus frame: it takes the eleven decoded frame fields, concatenates them into the 192-bit transmission and shifts it out MSB-first on a data/strobe pair, one bit per bit period. It is the transmit-side counterpart of the frame receiver and drives the same `serial_data`/`serial_clock` wire pair, so a receiver clocked from the same `clock` captures the frame bit-exact. A start/busy/done handshake lets a controller or test harness inject frames.

## Interface
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; legal range 2..65535.
- `GAP_CYCLES`, 16: idle cycles after the last bit before `done`; legal range 0..65535.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request to send; accepted only on a rising edge of `clock` where `busy` is 0.
- `preamble` input 32: frame bits [191:160].
- `type_1` input 16: bits [159:144].
- `type_2` input 16: bits [143:128].
- `constant` input 32: bits [127:96].
- `thermostat_id` input 32: bits [95:64].
- `room_temp` input 16: bits [63:48].
- `set_temp` input 16: bits [47:32].
- `state` input 8: bits [31:24].
- `tail_1` input 8: bits [23:16].
- `tail_2` input 8: bits [15:8].
- `tail_3` input 8: bits [7:0].
- `busy` output 1: a frame is in flight, from acceptance until `done`.
- `done` output 1: one-cycle pulse at the end of the gap.
- `serial_data` output 1: current bit.
- `serial_clock` output 1: one-cycle strobe per bit; the receiver samples `serial_data` while it is high.
- `bit_index` output 8: number of bits already strobed in the current frame, 0..192.

## Operation
- States are IDLE, SEND and GAP.
- IDLE → SEND when `start` is high at an edge. On that edge:
  - all fields are captured into a 192-bit shift register;
  - the bit counter and the divider are cleared;
  - `busy` is set.
- Input fields are don't-care after acceptance.
- SEND:
  - `serial_data` = shift register bit 191, held constant for the whole bit period.
  - A divider counts 0..CLKS_PER_BIT-1.
  - When the divider equals CLKS_PER_BIT/2 (integer division), `serial_clock` is high for that single cycle.
  - When the divider reaches CLKS_PER_BIT-1, the register shifts left by one, the divider wraps to 0, and `bit_index` increments.
  - After the period of bit 192 completes, the FSM goes to GAP.
- GAP:
  - `serial_data` = 0 and `serial_clock` = 0.
  - The counter runs GAP_CYCLES cycles, then `done` pulses and `busy` drops on the same edge. The FSM returns to IDLE.
  - If GAP_CYCLES = 0, `done` pulses on the edge that ends the last bit period.
- `start` while `busy` is ignored: no queuing and no restart.
- `start` on the same edge where `busy` falls is not accepted; `start` must be high on a later edge while `busy` is 0.
- `bit_index` reads 192 during GAP and stays at 192 in IDLE until the next acceptance clears it.
- Bit order is MSB first: preamble[31] is the first bit on the wire and tail_3[0] the last.

## Timing
- Reset values of all outputs are 0, asynchronously. The FSM resets to IDLE.
- Reset during SEND or GAP aborts the frame immediately, with no `done`. The next accepted `start` sends a complete frame from bit 191.
- Cycle numbering: acceptance edge = cycle 0.
  - `busy` = 1 and `serial_data` = frame[191] from cycle 1.
  - First strobe at cycle 1 + CLKS_PER_BIT/2.
  - Strobe k (k = 0..191) at cycle 1 + k·CLKS_PER_BIT + CLKS_PER_BIT/2.
- `serial_data` is stable for at least CLKS_PER_BIT/2 cycles before and CLKS_PER_BIT/2 − 1 cycles after each strobe.
- `done` pulses at cycle 1 + 192·CLKS_PER_BIT + GAP_CYCLES. `busy` is low from that cycle onward.
- Exactly 192 strobes per frame. `serial_clock` is never high outside SEND.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `bep_frame_pkg` holds the following; the receiver is updated to use it too:
  - `FRAME_BITS` = 192;
  - per-field MSB/LSB offset constants;
  - `BEP_PREAMBLE` = 32'hAAAAAAAA;
  - a frame-assembly function.
- Sub-module `bit_timer`:
  - parameter CLKS_PER_BIT; inputs `clock`, `reset` and `clear`;
  - outputs `mid` (strobe cycle) and `last` (end-of-period), each one cycle wide.
- The FSM, shift register, bit counter and gap counter live in the top module.

## Test plan
- CLKS_PER_BIT=4, GAP_CYCLES=16; fields AAAAAAAA, D391, D391, 0DFFFFFE, 02391F9F, 00C0, 0032, 19, 14, 03, 12; pulse `start`.
  - Exactly 192 strobes, first at cycle 3, strobe pitch 4 cycles.
  - `done` at cycle 785.
  - A loopback receiver reads back every field unchanged.
- Walking-one: only tail_3 = 01, all other fields 0 → only strobe 191 sees `serial_data` = 1.
- `start` held high continuously for 2000 cycles → frames back-to-back. Each new `busy` rises one edge after the previous `done`, i.e. the new acceptance happens at the edge right after the `done` edge.
- `start` pulsed at cycle 100 of a frame with different field values → the transmitted frame is unchanged and only one `done` is produced.
- `reset` asserted at cycle 300 → outputs are 0 within that cycle, with no `done`. A following `start` yields a complete 192-strobe frame.
- CLKS_PER_BIT=2, GAP_CYCLES=0 → strobe every 2nd cycle, first at cycle 2, `done` at cycle 385.
